conv_window_mac: RTL and testbench

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_mac_unit.sv | 29 ++
 rtl/conv_window_mac.sv | 123 ++++++++++++
 tb/tb_conv_window_mac.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and tap-geometry helpers for the 3x3 window MAC.
package conv_pkg;
  localparam int PIX_W   = 4;
  localparam int TAPS    = 9;
  localparam int ACC_W   = 12;
  localparam int SAT_LIM = 255;
  localparam int TAP_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2,
    ST_FIN  = 2'd3
  } conv_state_t;

  // Kernel tap t maps to window offset (t/3, t%3).
  function automatic logic [1:0] tap_row(input logic [TAP_W-1:0] t);
    case (t)
      4'd0, 4'd1, 4'd2: return 2'd0;
      4'd3, 4'd4, 4'd5: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] tap_col(input logic [TAP_W-1:0] t);
    case (t)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction
endpackage

// File: rtl/conv_mac_unit.sv
// Unsigned pixel x coefficient multiplier feeding a 12-bit accumulator.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int COEF_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] pix,
  input  logic [COEF_W-1:0] coef,
  output logic [ACC_W-1:0]  acc
);
  logic [DATA_W+COEF_W-1:0] prod;

  assign prod = pix * coef;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end
endmodule

// File: rtl/conv_window_mac.sv
// 4x4 image / 3x3 kernel valid convolution producing four outputs with ready/valid handshake.
// Build option CONV_SATURATE_EN clamps each output to 255.
module conv_window_mac
  import conv_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [63:0]       IMG_DATA,
  input  logic [35:0]       KER_DATA,
  output logic [ACC_W-1:0]  OUT_DATA,
  output logic [1:0]        OUT_IDX,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              BUSY,
  output logic              DONE
);
  conv_state_t      state_q, state_n;
  logic [63:0]      img_q;
  logic [35:0]      ker_q;
  logic [1:0]       idx_q;
  logic [TAP_W-1:0] tap_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] out_data_p0;
  logic             vld_p0;
  logic [1:0]       row_sel, col_sel;
  logic [3:0]       pix_idx;
  logic [PIX_W-1:0] pix_sel, coef_sel;
  logic             start_ok, accept, mac_clr, mac_en;

  function automatic logic [ACC_W-1:0] sat_out(input logic [ACC_W-1:0] a);
`ifdef CONV_SATURATE_EN
    return (a > ACC_W'(SAT_LIM)) ? ACC_W'(SAT_LIM) : a;
`else
    return a;
`endif
  endfunction

  assign start_ok = (state_q == ST_IDLE) && START;
  assign accept   = (state_q == ST_EMIT) && vld_p0 && OUT_READY;
  assign mac_clr  = start_ok || (accept && (idx_q != 2'd3));
  assign mac_en   = (state_q == ST_MAC);

  always_comb begin
    row_sel  = 2'(idx_q[1]) + tap_row(tap_q);
    col_sel  = 2'(idx_q[0]) + tap_col(tap_q);
    pix_idx  = {row_sel, col_sel};
    pix_sel  = img_q[PIX_W*pix_idx +: PIX_W];
    coef_sel = ker_q[PIX_W*tap_q +: PIX_W];
  end

  conv_mac_unit #(
    .DATA_W (PIX_W),
    .COEF_W (PIX_W)
  ) u_mac (
    .clk  (CLK),
    .rst_n(RESET),
    .clr  (mac_clr),
    .en   (mac_en),
    .pix  (pix_sel),
    .coef (coef_sel),
    .acc  (acc)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (START) state_n = ST_MAC;
      ST_MAC:  if (tap_q == TAP_W'(TAPS-1)) state_n = ST_EMIT;
      ST_EMIT: if (accept) state_n = (idx_q == 2'd3) ? ST_FIN : ST_MAC;
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Capture/tap sequencing, then the emit stage holding the result until accepted
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      img_q       <= '0;
      ker_q       <= '0;
      idx_q       <= '0;
      tap_q       <= '0;
      out_data_p0 <= '0;
      vld_p0      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            img_q <= IMG_DATA;
            ker_q <= KER_DATA;
            idx_q <= '0;
            tap_q <= '0;
          end
        end
        ST_MAC: begin
          tap_q <= (tap_q == TAP_W'(TAPS-1)) ? '0 : tap_q + 4'd1;
        end
        ST_EMIT: begin
          if (!vld_p0) begin
            vld_p0      <= 1'b1;
            out_data_p0 <= sat_out(acc);
          end else if (OUT_READY) begin
            vld_p0 <= 1'b0;
            tap_q  <= '0;
            if (idx_q != 2'd3) idx_q <= idx_q + 2'd1;
          end
        end
        default: vld_p0 <= 1'b0;
      endcase
    end
  end

  assign OUT_DATA  = out_data_p0;
  assign OUT_VALID = vld_p0;
  assign OUT_IDX   = idx_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_FIN);
endmodule

// File: tb/tb_conv_window_mac.sv
// Directed + randomized bench for conv_window_mac against an arithmetic convolution model.
module tb_conv_window_mac;
  logic        CLK = 1'b0;
  logic        RESET, START, OUT_READY;
  logic [63:0] IMG_DATA;
  logic [35:0] KER_DATA;
  logic [11:0] OUT_DATA;
  logic [1:0]  OUT_IDX;
  logic        OUT_VALID, BUSY, DONE;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 CLK = ~CLK;

  conv_window_mac dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .IMG_DATA (IMG_DATA),
    .KER_DATA (KER_DATA),
    .OUT_DATA (OUT_DATA),
    .OUT_IDX  (OUT_IDX),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  function automatic logic [11:0] ref_out(input logic [63:0] img, input logic [35:0] ker, input int p);
    int pix [4][4];
    int k [9];
    int sum;
    int r0;
    int c0;
    r0 = p / 2;
    c0 = p % 2;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pix[r][c] = int'(img[4*(4*r+c) +: 4]);
    for (int t = 0; t < 9; t++) k[t] = int'(ker[4*t +: 4]);
    sum = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sum += pix[r0+i][c0+j] * k[3*i+j];
`ifdef CONV_SATURATE_EN
    if (sum > 255) sum = 255;
`endif
    return 12'(sum);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(OUT_VALID), 0);
    chk({tag, "_data"},  32'(OUT_DATA),  0);
    chk({tag, "_idx"},   32'(OUT_IDX),   0);
    chk({tag, "_busy"},  32'(BUSY),      0);
    chk({tag, "_done"},  32'(DONE),      0);
  endtask

  task automatic run_frame(input logic [63:0] img, input logic [35:0] ker,
                           input int stall_k, input bit inject, input bit abort);
    logic [11:0] exp_q [4];
    int cyc;
    for (int p = 0; p < 4; p++) exp_q[p] = ref_out(img, ker, p);
    @(negedge CLK);
    IMG_DATA  = img;
    KER_DATA  = ker;
    START     = 1'b1;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("busy_after_start", 32'(BUSY), 1);
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (!OUT_VALID && cyc < 40) begin
        if (inject && k == 0 && cyc == 3) begin
          START    = 1'b1;
          IMG_DATA = ~img;
          KER_DATA = ~ker;
        end else begin
          START = 1'b0;
        end
        if (abort && k == 2 && cyc == 4) begin
          RESET = 1'b0;
          #1;
          chk_reset_state("abort");
          return;
        end
        @(posedge CLK); #1;
        cyc++;
      end
      START = 1'b0;
      chk("latency", 32'(cyc), 10);
      chk("valid_high", 32'(OUT_VALID), 1);
      chk("out_data", 32'(OUT_DATA), 32'(exp_q[k]));
      chk("out_idx", 32'(OUT_IDX), 32'(k));
      chk("done_early", 32'(DONE), 0);
      if (k == stall_k) begin
        OUT_READY = 1'b0;
        repeat (5) begin
          @(posedge CLK); #1;
          chk("stall_valid", 32'(OUT_VALID), 1);
          chk("stall_data", 32'(OUT_DATA), 32'(exp_q[k]));
          chk("stall_idx", 32'(OUT_IDX), 32'(k));
        end
        OUT_READY = 1'b1;
      end
      @(posedge CLK); #1;
      chk("valid_drop", 32'(OUT_VALID), 0);
      if (k == 3) begin
        chk("done_pulse", 32'(DONE), 1);
        @(posedge CLK); #1;
        chk("done_clear", 32'(DONE), 0);
        chk("idle_busy", 32'(BUSY), 0);
      end else begin
        chk("done_mid", 32'(DONE), 0);
      end
    end
  endtask

  function automatic logic [63:0] rnd_img();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [35:0] rnd_ker();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[35:0];
  endfunction

  initial begin
    logic [63:0] ramp;
    logic [35:0] centre;
    RESET     = 1'b1;
    START     = 1'b0;
    OUT_READY = 1'b0;
    IMG_DATA  = '0;
    KER_DATA  = '0;
    #2 RESET = 1'b0;
    #1;
    chk_reset_state("reset");
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // all ones: every output is 9
    run_frame({16{4'h1}}, {9{4'h1}}, -1, 1'b0, 1'b0);

    // ramp image with centre-only kernel: 5, 6, 9, 10
    for (int i = 0; i < 16; i++) ramp[4*i +: 4] = 4'(i);
    centre = '0;
    centre[16 +: 4] = 4'h1;
    run_frame(ramp, centre, -1, 1'b0, 1'b0);

    // maximum operands
    run_frame({16{4'hF}}, {9{4'hF}}, -1, 1'b0, 1'b0);

    // backpressure on idx 1
    run_frame(rnd_img(), rnd_ker(), 1, 1'b0, 1'b0);

    // START re-pulsed with new data during MAC
    run_frame(rnd_img(), rnd_ker(), -1, 1'b1, 1'b0);

    // reset at tap 4 of idx 2, then a fresh frame
    run_frame(rnd_img(), rnd_ker(), -1, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      chk("post_abort_done", 32'(DONE), 0);
      chk("post_abort_busy", 32'(BUSY), 0);
    end
    run_frame(rnd_img(), rnd_ker(), -1, 1'b0, 1'b0);

    for (int n = 0; n < 4; n++)
      run_frame(rnd_img(), rnd_ker(), (n == 2) ? 3 : -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
